sobel_column_feeder: RTL and testbench
======================================

SOBEL_COLUMN_FEEDER -- requirements
Module: sobel_column_feeder

Interface
REQ-001 Parameter: IMG_WIDTH, default 640, pixels per image row (2..4096).
REQ-002 Parameter: PIX_W, default 8, pixel width in bits.
REQ-003 CLOCK  input  1  clock; all state updates on rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-high.
REQ-005 pix_in  input  PIX_W  raster-order input pixel.
REQ-006 pix_valid  input  1  pix_in is valid this cycle.
REQ-007 pix_sof  input  1  qualified by pix_valid; pix_in is pixel (0,0) of a new frame.
REQ-008 pix_ready  output  1  block accepts pix_in this cycle.
REQ-009 input_row_a00  output  PIX_W  column pixel from row y-2 (oldest).
REQ-010 input_row_a01  output  PIX_W  column pixel from row y-1.
REQ-011 input_row_a02  output  PIX_W  column pixel from row y (current).
REQ-012 col_valid  output  1  the three column outputs are valid.
REQ-013 col_ready  input  1  downstream sobel stage accepts the column; tie high for the free-running sobel core.
REQ-014 col_sof  output  1  qualified by col_valid; first column of the frame's first output row.
REQ-015 col_eol  output  1  qualified by col_valid; column x = IMG_WIDTH-1.

Function
REQ-016 A pixel is accepted on a cycle where pix_valid and pix_ready are both 1; a column is consumed on a cycle where col_valid and col_ready are both 1.
REQ-017 pix_ready SHALL equal (!col_valid || col_ready), combinationally.
REQ-018 Two line memories (LM0 = row y-2, LM1 = row y-1) of IMG_WIDTH x PIX_W SHALL be indexed by column counter x.
REQ-019 On accept at column x: read LM0[x] and LM1[x] old contents, then write LM0[x] <= LM1[x] and LM1[x] <= pix_in in the same cycle (read-before-write).
REQ-020 Column counter x: 0..IMG_WIDTH-1, increments per accept, wraps to 0 after IMG_WIDTH-1.
REQ-021 FSM states PRIME0 (row 0), PRIME1 (row 1), STREAM (rows >= 2); PRIME0->PRIME1 and PRIME1->STREAM on accept with x = IMG_WIDTH-1; STREAM persists until pix_sof or reset.
REQ-022 In PRIME0/PRIME1 accepted pixels update memories only; no column is produced.
REQ-023 In STREAM each accept SHALL load the output register with (LM0[x], LM1[x], pix_in) onto (a00, a01, a02) and set col_valid = 1 on the next cycle (latency 1 cycle).
REQ-024 col_sof SHALL be 1 for the column produced from the first accept of the first STREAM row after pix_sof/reset; col_eol SHALL be 1 when the producing accept had x = IMG_WIDTH-1.
REQ-025 col_valid clears after consumption if no new accept occurs in the same cycle; simultaneous consume and accept SHALL keep col_valid = 1 with new data (full throughput, one column per cycle).
REQ-026 While col_valid = 1 and col_ready = 0, all column outputs and flags SHALL hold stable.
REQ-027 pix_sof on an accept SHALL force x = 0 and state PRIME0 before processing that pixel (pixel written as x = 0, row 0); mid-row pix_sof aborts the current frame; line memories are not cleared; a pending output column is still delivered.
REQ-028 pix_sof with pix_valid = 0 SHALL be ignored.

Reset
REQ-029 RESET SHALL set state = PRIME0, x = 0, col_valid = 0, col_sof = 0, col_eol = 0, input_row_a00/a01/a02 = 0 asynchronously.
REQ-030 Line memory contents SHALL not be reset; pix_ready = 1 immediately after reset.
REQ-031 Reset mid-frame SHALL discard any pending column; the next frame starts at PRIME0 regardless of pix_sof.

Structure
REQ-032 Shared package sobel_pkg SHALL hold PIX_W default and the FSM state enumeration (PRIME0, PRIME1, STREAM).
REQ-033 One sub-module sobel_line_ram: single-clock, IMG_WIDTH x PIX_W, one read and one write port at the same address, read-first; instantiated twice.

Verification (IMG_WIDTH = 4)
REQ-034 Rows 1,2,3,4 / 11,12,13,14 / 21,22,23,24 streamed with col_ready = 1 -> columns (1,11,21),(2,12,22),(3,13,23),(4,14,24), col_sof on first, col_eol on last, each 1 cycle after its accept.
REQ-035 Continue with row 31..34 -> columns (11,21,31)..(14,24,34), col_sof = 0.
REQ-036 col_ready = 0 for 3 cycles while col_valid = 1 -> outputs held, pix_ready = 0, no pixel lost; streaming resumes in order.
REQ-037 pix_sof at row 2, x = 2 -> no column produced for next 8 accepts, then col_sof on the first column of the new frame.
REQ-038 RESET asserted mid-row 3 with col_valid = 1 -> all outputs 0 and col_valid = 0 within the reset cycle; 8 priming pixels precede the next column.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel column feeder.
// Holds the pixel width default and the priming FSM encoding.
package sobel_pkg;

   localparam int PIX_W_DEF = 8;

   typedef enum logic [1:0] {
      PRIME0 = 2'd0,
      PRIME1 = 2'd1,
      STREAM = 2'd2
   } feed_state_t;

endpackage

// File: rtl/sobel_line_ram.sv
// One image row of pixel storage.
// Combinational read and synchronous write at one shared address (read-first).
module sobel_line_ram
   import sobel_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int W     = PIX_W_DEF,
   parameter int AW    = 10
) (
   input  logic          CLOCK,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge CLOCK) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/sobel_column_feeder.sv
// Turns a raster pixel stream into 3-row columns for a 3x3 sobel core.
// Two line memories hold rows y-2 and y-1; a one-deep output register decouples downstream.
module sobel_column_feeder
   import sobel_pkg::*;
#(
   parameter int IMG_WIDTH = 640,
   parameter int PIX_W     = PIX_W_DEF
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   input  logic             pix_sof,
   output logic             pix_ready,
   output logic [PIX_W-1:0] input_row_a00,
   output logic [PIX_W-1:0] input_row_a01,
   output logic [PIX_W-1:0] input_row_a02,
   output logic             col_valid,
   input  logic             col_ready,
   output logic             col_sof,
   output logic             col_eol
);

   localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);

   feed_state_t state;
   feed_state_t state_eff;
   logic [XW-1:0] x;
   logic [XW-1:0] x_eff;
   logic accept;
   logic consume;
   logic sof_acc;
   logic x_last;
   logic sof_arm;
   logic [PIX_W-1:0] lm0_rd;
   logic [PIX_W-1:0] lm1_rd;

   assign pix_ready = !col_valid || col_ready;
   assign accept    = pix_valid && pix_ready;
   assign consume   = col_valid && col_ready;

   // A start-of-frame pixel is processed as (0,0) of a fresh frame.
   assign sof_acc   = pix_valid && pix_sof;
   assign x_eff     = sof_acc ? '0 : x;
   assign state_eff = sof_acc ? PRIME0 : state;
   assign x_last    = (x_eff == X_LAST);

   sobel_line_ram #(
      .DEPTH (IMG_WIDTH),
      .W     (PIX_W),
      .AW    (XW)
   ) u_lm0 (
      .CLOCK (CLOCK),
      .we    (accept),
      .addr  (x_eff),
      .wdata (lm1_rd),
      .rdata (lm0_rd)
   );

   sobel_line_ram #(
      .DEPTH (IMG_WIDTH),
      .W     (PIX_W),
      .AW    (XW)
   ) u_lm1 (
      .CLOCK (CLOCK),
      .we    (accept),
      .addr  (x_eff),
      .wdata (pix_in),
      .rdata (lm1_rd)
   );

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state         <= PRIME0;
         x             <= '0;
         sof_arm       <= 1'b0;
         col_valid     <= 1'b0;
         col_sof       <= 1'b0;
         col_eol       <= 1'b0;
         input_row_a00 <= '0;
         input_row_a01 <= '0;
         input_row_a02 <= '0;
      end else if (accept) begin
         x       <= x_last ? '0 : x_eff + 1'b1;
         state   <= state_eff;
         sof_arm <= sof_arm && !sof_acc;
         unique case (state_eff)
            PRIME0: begin
               if (x_last) begin
                  state <= PRIME1;
               end
               if (consume) begin
                  col_valid <= 1'b0;
               end
            end
            PRIME1: begin
               if (x_last) begin
                  state   <= STREAM;
                  sof_arm <= 1'b1;
               end
               if (consume) begin
                  col_valid <= 1'b0;
               end
            end
            STREAM: begin
               input_row_a00 <= lm0_rd;
               input_row_a01 <= lm1_rd;
               input_row_a02 <= pix_in;
               col_valid     <= 1'b1;
               col_sof       <= sof_arm;
               col_eol       <= x_last;
               sof_arm       <= 1'b0;
            end
            default: begin
               state <= PRIME0;
            end
         endcase
      end else if (consume) begin
         col_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sobel_column_feeder.sv
// Bench for sobel_column_feeder at IMG_WIDTH = 4.
// Table of pixels with expected columns; a scoreboard checks columns as they are consumed.
module tb_sobel_column_feeder;

   localparam int W  = 4;
   localparam int PW = 8;

   logic          CLOCK = 1'b0;
   logic          RESET;
   logic [PW-1:0] pix_in;
   logic          pix_valid;
   logic          pix_sof;
   logic          pix_ready;
   logic [PW-1:0] a00;
   logic [PW-1:0] a01;
   logic [PW-1:0] a02;
   logic          col_valid;
   logic          col_ready;
   logic          col_sof;
   logic          col_eol;

   typedef struct {
      logic [7:0] pix;
      bit         sof;
      bit         expv;
      logic [7:0] a00;
      logic [7:0] a01;
      logic [7:0] a02;
      bit         csof;
      bit         ceol;
   } vec_t;

   typedef struct {
      logic [7:0] a00;
      logic [7:0] a01;
      logic [7:0] a02;
      bit         sof;
      bit         eol;
      longint     t;
      bit         lat;
   } col_t;

   vec_t tbl[$];
   col_t sb[$];
   int n_chk  = 0;
   int n_fail = 0;

   sobel_column_feeder #(
      .IMG_WIDTH (W),
      .PIX_W     (PW)
   ) dut (
      .CLOCK         (CLOCK),
      .RESET         (RESET),
      .pix_in        (pix_in),
      .pix_valid     (pix_valid),
      .pix_sof       (pix_sof),
      .pix_ready     (pix_ready),
      .input_row_a00 (a00),
      .input_row_a01 (a01),
      .input_row_a02 (a02),
      .col_valid     (col_valid),
      .col_ready     (col_ready),
      .col_sof       (col_sof),
      .col_eol       (col_eol)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic add(input int pix, input bit sof, input bit v,
                      input int a, input int b, input int c,
                      input bit s, input bit e);
      vec_t r;
      r.pix  = 8'(pix);
      r.sof  = sof;
      r.expv = v;
      r.a00  = 8'(a);
      r.a01  = 8'(b);
      r.a02  = 8'(c);
      r.csof = s;
      r.ceol = e;
      tbl.push_back(r);
   endtask

   task automatic prime(input int base, input bit sof);
      for (int k = 0; k < W; k++) begin
         add(base + k + 1, sof && (k == 0), 1'b0, 0, 0, 0, 1'b0, 1'b0);
      end
   endtask

   task automatic stream(input int b2, input int b1, input int b0,
                         input bit cs, input int n);
      for (int k = 0; k < n; k++) begin
         add(b0 + k + 1, 1'b0, 1'b1, b2 + k + 1, b1 + k + 1, b0 + k + 1,
             cs && (k == 0), k == W - 1);
      end
   endtask

   task automatic send(input vec_t v, input bit lat);
      bit acc;
      int n;
      col_t e;
      pix_in    = v.pix;
      pix_sof   = v.sof;
      pix_valid = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
         @(negedge CLOCK);
         acc = pix_ready;
         @(posedge CLOCK);
         n++;
      end
      if (!acc) begin
         chk("accept_timeout", 0, 1);
      end else if (v.expv) begin
         e.a00 = v.a00;
         e.a01 = v.a01;
         e.a02 = v.a02;
         e.sof = v.csof;
         e.eol = v.ceol;
         e.t   = longint'($time);
         e.lat = lat;
         sb.push_back(e);
      end
      #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   always @(negedge CLOCK) begin : mon
      col_t e;
      if (RESET === 1'b0 && col_valid === 1'b1 && col_ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_col", int'(a02), -1);
         end else begin
            e = sb.pop_front();
            chk("col_a00", int'(a00), int'(e.a00));
            chk("col_a01", int'(a01), int'(e.a01));
            chk("col_a02", int'(a02), int'(e.a02));
            chk("col_sof", int'(col_sof), int'(e.sof));
            chk("col_eol", int'(col_eol), int'(e.eol));
            if (e.lat) begin
               chk("col_latency", int'(longint'($time) - e.t), 5);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET     = 1'b1;
      pix_in    = '0;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      col_ready = 1'b1;

      prime(0, 1'b1);
      prime(10, 1'b0);
      stream(0, 10, 20, 1'b1, 4);
      stream(10, 20, 30, 1'b0, 4);
      stream(20, 30, 40, 1'b0, 4);
      prime(50, 1'b1);
      prime(60, 1'b0);
      stream(50, 60, 70, 1'b1, 2);
      prime(80, 1'b1);
      prime(90, 1'b0);
      stream(80, 90, 100, 1'b1, 4);
      stream(90, 100, 110, 1'b0, 2);
      prime(120, 1'b0);
      prime(130, 1'b0);
      stream(120, 130, 140, 1'b1, 4);

      @(posedge CLOCK);
      #1;
      chk("rst_col_valid", int'(col_valid), 0);
      chk("rst_a00", int'(a00), 0);
      chk("rst_a01", int'(a01), 0);
      chk("rst_a02", int'(a02), 0);
      chk("rst_col_sof", int'(col_sof), 0);
      chk("rst_col_eol", int'(col_eol), 0);
      chk("rst_pix_ready", int'(pix_ready), 1);
      @(negedge CLOCK);
      RESET = 1'b0;
      @(posedge CLOCK);
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         send(tbl[i], i != 16);

         // Stall with column (21,31,41) pending and pixel 42 offered.
         if (i == 16) begin
            col_ready = 1'b0;
            pix_valid = 1'b1;
            pix_in    = tbl[17].pix;
            for (int s = 0; s < 3; s++) begin
               @(negedge CLOCK);
               chk("stall_pix_ready", int'(pix_ready), 0);
               chk("stall_col_valid", int'(col_valid), 1);
               if (sb.size() > 0) begin
                  chk("stall_a00", int'(a00), int'(sb[0].a00));
                  chk("stall_a01", int'(a01), int'(sb[0].a01));
                  chk("stall_a02", int'(a02), int'(sb[0].a02));
                  chk("stall_sof", int'(col_sof), int'(sb[0].sof));
                  chk("stall_eol", int'(col_eol), int'(sb[0].eol));
               end else begin
                  chk("stall_sb_empty", 0, 1);
               end
               @(posedge CLOCK);
               #1;
            end
            col_ready = 1'b1;
            pix_valid = 1'b0;
         end

         // Reset with column (92,102,112) still pending.
         if (i == 43) begin
            chk("pend_before_rst", int'(col_valid), 1);
            RESET = 1'b1;
            #1;
            chk("mrst_col_valid", int'(col_valid), 0);
            chk("mrst_a00", int'(a00), 0);
            chk("mrst_a01", int'(a01), 0);
            chk("mrst_a02", int'(a02), 0);
            chk("mrst_col_sof", int'(col_sof), 0);
            chk("mrst_col_eol", int'(col_eol), 0);
            chk("mrst_pix_ready", int'(pix_ready), 1);
            if (sb.size() > 0) begin
               void'(sb.pop_back());
            end
            @(negedge CLOCK);
            RESET = 1'b0;
            @(posedge CLOCK);
            #1;
         end

         // A start-of-frame flag without valid must be ignored.
         if (i == 45) begin
            pix_sof = 1'b1;
            @(posedge CLOCK);
            #1;
            pix_sof = 1'b0;
         end
      end

      repeat (4) @(posedge CLOCK);
      #1;
      chk("sb_leftover", sb.size(), 0);
      chk("final_col_valid", int'(col_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
